// File: rtl/cache_sa_pkg.sv
// Shared types, width helpers and tree-PLRU functions for the set-associative cache controller.
// PLRU bits point at the least-recently-used side; up to 4 ways (3 bits) are supported.
package cache_sa_pkg;

    typedef enum logic [1:0] {IDLE, FILL, WR, WR_ACK} state_t;

    function automatic int unsigned off_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned idx_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets,
                                          input int unsigned line_words);
        return addr_w - $clog2(sets) - $clog2(line_words);
    endfunction

    function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way,
                                              input int unsigned ways);
        logic [2:0] nb;
        nb = bits;
        if (ways == 2) begin
            nb[0] = ~way[0];
        end else if (ways == 4) begin
            nb[0] = ~way[1];
            if (way[1]) nb[2] = ~way[0];
            else        nb[1] = ~way[0];
        end
        return nb;
    endfunction

    function automatic logic [1:0] plru_victim(input logic [2:0] bits, input int unsigned ways);
        logic [1:0] v;
        v = 2'b00;
        if (ways == 2)      v = {1'b0, bits[0]};
        else if (ways == 4) v = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
        return v;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Per-set tree-PLRU state with a touch port (protect a way) and a combinational victim port.
module plru_tree
    import cache_sa_pkg::*;
#(
    parameter int unsigned SETS  = 64,
    parameter int unsigned WAYS  = 2,
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             touch_en,
    input  logic [IDX_W-1:0] touch_idx,
    input  logic [1:0]       touch_way,
    input  logic [IDX_W-1:0] vic_idx,
    output logic [1:0]       vic_way
);

    logic [2:0] bits [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) bits[s] <= '0;
        end else if (flush) begin
            for (int unsigned s = 0; s < SETS; s++) bits[s] <= '0;
        end else if (touch_en) begin
            bits[touch_idx] <= plru_touch(bits[touch_idx], touch_way, WAYS);
        end
    end

    assign vic_way = plru_victim(bits[vic_idx], WAYS);

endmodule

// File: rtl/cache_ctrl_sa.sv
// Set-associative write-through, no-write-allocate data cache between EX/MEM and external SRAM.
// Read hits return combinationally; read misses fill a whole line, writes always go to SRAM.
module cache_ctrl_sa
    import cache_sa_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned SETS       = 64,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_WORDS = 2,
    parameter int unsigned SRAM_LAT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              cache_flush,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int unsigned OFF_W = off_w(LINE_WORDS);
    localparam int unsigned IDX_W = idx_w(SETS);
    localparam int unsigned TAG_W = tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam int unsigned DA_W  = IDX_W + OFF_W;
    localparam int unsigned WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned CW    = $clog2(SRAM_LAT);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS - 1);
    localparam logic [CW-1:0]     CYC_LAST = CW'(SRAM_LAT - 1);
    localparam logic [CW-1:0]     CYC_WE   = CW'(SRAM_LAT - 2);

    state_t            state;
    logic [WAYS-1:0]   valid    [SETS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [DATA_W-1:0] data_mem [WAYS][SETS*LINE_WORDS];
    logic [CW-1:0]     cyc;
    logic [WW-1:0]     vic_r;
    logic              from_fill;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [DA_W-1:0]   da;
    logic              hit;
    logic [WW-1:0]     hit_way;
    logic [WW-1:0]     vic_way;
    logic [1:0]        plru_way;
    logic              do_flush, do_wr, rd_req, do_rd_hit, do_rd_miss;
    logic              fill_last_cyc, fill_done;
    logic              mem_we;
    logic [WW-1:0]     mem_way;
    logic [DA_W-1:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Data RAM address is simply {index, offset}, i.e. the low bits of the word address.
    assign da  = cpu_addr[DA_W-1:0];
    assign idx = cpu_addr[DA_W-1 -: IDX_W];
    assign tag = cpu_addr[ADDR_W-1 -: TAG_W];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid[idx][w] && tag_mem[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    always_comb begin
        vic_way = WW'(plru_way);
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (!valid[idx][w-1]) vic_way = WW'(w - 1);
        end
    end

    assign do_flush   = (state == IDLE) && cache_flush;
    assign do_wr      = (state == IDLE) && !cache_flush && cpu_wr;
    assign rd_req     = (state == IDLE) && !cache_flush && !cpu_wr && cpu_rd;
    assign do_rd_hit  = rd_req && hit;
    assign do_rd_miss = rd_req && !hit;

    assign cpu_stall = (state == FILL) || (state == WR) || do_flush || do_wr || do_rd_miss;
    assign cpu_rdata = do_rd_hit ? data_mem[hit_way][da] : '0;

    assign fill_last_cyc = (state == FILL) && (cyc == CYC_LAST);
    assign fill_done     = fill_last_cyc && ((sram_addr & OFF_MASK) == OFF_MASK);

    assign mem_we    = fill_last_cyc || (do_wr && hit);
    assign mem_way   = (state == FILL) ? vic_r : hit_way;
    assign mem_addr  = (state == FILL) ? sram_addr[DA_W-1:0] : da;
    assign mem_wdata = (state == FILL) ? sram_rdata : cpu_wdata;

    always_ff @(posedge clk) begin
        if (mem_we) data_mem[mem_way][mem_addr] <= mem_wdata;
        if (fill_done) tag_mem[vic_r][sram_addr[DA_W-1 -: IDX_W]] <= sram_addr[ADDR_W-1 -: TAG_W];
    end

    plru_tree #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .IDX_W (IDX_W)
    ) u_plru (
        .clk       (clk),
        .rst_n     (rst),
        .flush     (do_flush),
        .touch_en  (do_rd_hit),
        .touch_idx (idx),
        .touch_way (2'(hit_way)),
        .vic_idx   (idx),
        .vic_way   (plru_way)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            for (int unsigned s = 0; s < SETS; s++) valid[s] <= '0;
            cyc        <= '0;
            vic_r      <= '0;
            from_fill  <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
        end else begin
            from_fill <= (state == FILL);
            case (state)
                IDLE: begin
                    if (cache_flush) begin
                        for (int unsigned s = 0; s < SETS; s++) valid[s] <= '0;
                    end else if (cpu_wr) begin
                        state      <= WR;
                        cyc        <= '0;
                        sram_addr  <= cpu_addr;
                        sram_wdata <= cpu_wdata;
                        sram_dq_oe <= 1'b1;
                        sram_ce_n  <= 1'b0;
                        sram_we_n  <= 1'b0;
                        sram_ub_n  <= 1'b0;
                        sram_lb_n  <= 1'b0;
                    end else if (cpu_rd) begin
                        if (hit) begin
                            if (!from_fill && hit_cnt != '1) hit_cnt <= hit_cnt + 16'd1;
                        end else begin
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + 16'd1;
                            state     <= FILL;
                            cyc       <= '0;
                            vic_r     <= vic_way;
                            sram_addr <= cpu_addr & ~OFF_MASK;
                            sram_ce_n <= 1'b0;
                            sram_oe_n <= 1'b0;
                            sram_ub_n <= 1'b0;
                            sram_lb_n <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    if (cyc == CYC_LAST) begin
                        cyc <= '0;
                        if ((sram_addr & OFF_MASK) == OFF_MASK) begin
                            valid[sram_addr[DA_W-1 -: IDX_W]][vic_r] <= 1'b1;
                            state     <= IDLE;
                            sram_ce_n <= 1'b1;
                            sram_oe_n <= 1'b1;
                            sram_ub_n <= 1'b1;
                            sram_lb_n <= 1'b1;
                        end else begin
                            sram_addr <= sram_addr + ADDR_W'(1);
                        end
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                WR: begin
                    // Release we_n one cycle early so address/data are held past the strobe.
                    if (cyc == CYC_WE) sram_we_n <= 1'b1;
                    if (cyc == CYC_LAST) begin
                        state      <= WR_ACK;
                        sram_dq_oe <= 1'b0;
                        sram_ce_n  <= 1'b1;
                        sram_ub_n  <= 1'b1;
                        sram_lb_n  <= 1'b1;
                    end else begin
                        cyc <= cyc + CW'(1);
                    end
                end
                WR_ACK:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_sa.sv
// Directed bench for cache_ctrl_sa with default parameters and a behavioural SRAM model.
module tb_cache_ctrl_sa;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd, cpu_wr, cache_flush;
    logic [17:0] cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [15:0] hit_cnt, miss_cnt;

    int tests = 0;
    int fails = 0;

    logic [15:0] mem [0:262143];
    int          we_cycles = 0;
    int          oe_cycles = 0;
    logic [17:0] rd_addrs [$];

    always #5 clk = ~clk;

    cache_ctrl_sa #(
        .DATA_W(16), .ADDR_W(18), .SETS(64), .WAYS(2), .LINE_WORDS(2), .SRAM_LAT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cache_flush(cache_flush),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    assign sram_rdata = mem[sram_addr];

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            we_cycles++;
            mem[sram_addr] = sram_wdata;
        end
        if (sram_dq_oe) oe_cycles++;
        if (!sram_ce_n && !sram_oe_n &&
            (rd_addrs.size() == 0 || rd_addrs[rd_addrs.size()-1] != sram_addr))
            rd_addrs.push_back(sram_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [17:0] a, output int stalls, output logic [15:0] data);
        @(negedge clk);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        cpu_wr   = 1'b0;
        #1;
        stalls = 0;
        while (cpu_stall && stalls < 200) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        data = cpu_rdata;
        @(negedge clk);
        cpu_rd = 1'b0;
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] d, output int stalls);
        @(negedge clk);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wr    = 1'b1;
        cpu_rd    = 1'b0;
        #1;
        stalls = 0;
        while (cpu_stall && stalls < 200) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        @(negedge clk);
        cpu_wr = 1'b0;
    endtask

    initial begin
        int          st;
        int          base;
        int          we0, oe0;
        logic [15:0] rd;

        for (int i = 0; i < 262144; i++) mem[i] = 16'(i) ^ 16'h5A3C;
        rst = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cache_flush = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_ublb", 32'({sram_ub_n, sram_lb_n}), 32'd3);
        check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_wdata", 32'(sram_wdata), 32'd0);
        check("rst_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_cnts", {hit_cnt, miss_cnt}, 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Cold read miss, then a hit on the other word of the same line
        base = rd_addrs.size();
        do_read(18'h00010, st, rd);
        check("cold_stall", 32'(st), 32'd9);
        check("cold_data", 32'(rd), 32'h5A2C);
        check("cold_miss", 32'(miss_cnt), 32'd1);
        check("cold_hit", 32'(hit_cnt), 32'd0);
        check("cold_nrd", 32'(rd_addrs.size() - base), 32'd2);
        check("cold_rd0", 32'(rd_addrs[base]), 32'h00010);
        check("cold_rd1", 32'(rd_addrs[base+1]), 32'h00011);
        do_read(18'h00011, st, rd);
        check("hit_stall", 32'(st), 32'd0);
        check("hit_data", 32'(rd), 32'h5A2D);
        check("hit_cnt1", 32'(hit_cnt), 32'd1);

        // Write hit: write-through plus cached copy update
        we0 = we_cycles; oe0 = oe_cycles;
        do_write(18'h00010, 16'hBEEF, st);
        check("wr_stall", 32'(st), 32'd5);
        check("wr_we_cyc", 32'(we_cycles - we0), 32'd3);
        check("wr_oe_cyc", 32'(oe_cycles - oe0), 32'd4);
        check("wr_sram", 32'(mem[18'h00010]), 32'hBEEF);
        do_read(18'h00010, st, rd);
        check("wrhit_stall", 32'(st), 32'd0);
        check("wrhit_data", 32'(rd), 32'hBEEF);
        check("wrhit_cnt", 32'(hit_cnt), 32'd2);

        // Write miss: no allocation
        do_write(18'h02000, 16'h1234, st);
        check("wm_stall", 32'(st), 32'd5);
        check("wm_miss", 32'(miss_cnt), 32'd1);
        check("wm_sram", 32'(mem[18'h02000]), 32'h1234);
        do_read(18'h02000, st, rd);
        check("wm_rd_stall", 32'(st), 32'd9);
        check("wm_rd_data", 32'(rd), 32'h1234);
        check("wm_rd_miss", 32'(miss_cnt), 32'd2);

        // Set 0 replacement: A, B, A, C -> C evicts B
        do_read(18'h00080, st, rd);
        check("A_miss", 32'(st), 32'd9);
        do_read(18'h00100, st, rd);
        check("B_miss", 32'(st), 32'd9);
        check("B_data", 32'(rd), 32'h5B3C);
        do_read(18'h00080, st, rd);
        check("A_hit", 32'(st), 32'd0);
        check("A_data", 32'(rd), 32'h5ABC);
        do_read(18'h00180, st, rd);
        check("C_miss", 32'(st), 32'd9);
        check("C_data", 32'(rd), 32'h5BBC);
        do_read(18'h00080, st, rd);
        check("A_hit2", 32'(st), 32'd0);
        do_read(18'h00100, st, rd);
        check("B_evicted", 32'(st), 32'd9);
        check("plru_cnts", {hit_cnt, miss_cnt}, {16'd4, 16'd6});

        // Flush: one stall cycle, then previously cached line misses
        @(negedge clk);
        cache_flush = 1'b1;
        #1;
        check("flush_stall", 32'(cpu_stall), 32'd1);
        @(negedge clk);
        cache_flush = 1'b0;
        #1;
        check("flush_done", 32'(cpu_stall), 32'd0);
        do_read(18'h00010, st, rd);
        check("flush_miss", 32'(st), 32'd9);
        check("flush_data", 32'(rd), 32'hBEEF);
        check("flush_mcnt", 32'(miss_cnt), 32'd7);

        // Reset in the third FILL cycle aborts the fill
        @(negedge clk);
        cpu_addr = 18'h00400;
        cpu_rd   = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_fill_oe", 32'(sram_oe_n), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_ce_n", 32'(sram_ce_n), 32'd1);
        check("abort_oe_n", 32'(sram_oe_n), 32'd1);
        check("abort_cnts", {hit_cnt, miss_cnt}, 32'd0);
        cpu_rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_read(18'h00400, st, rd);
        check("post_rst_stall", 32'(st), 32'd9);
        check("post_rst_data", 32'(rd), 32'h5E3C);
        check("post_rst_cnts", {hit_cnt, miss_cnt}, {16'd0, 16'd1});

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_sa.md
Name: cache_ctrl_sa

Overview:
Parametrised set-associative, write-through, no-write-allocate data cache controller for the 16-bit pipelined MIPS core. It sits between the EX/MEM stage register and the external SRAM. It serves read hits with zero added latency and stalls the pipeline via cpu_stall on read misses and on writes. Generalises the fixed cache controller with configurable ways, sets, line length and SRAM access latency, tree-PLRU replacement, single-cycle flush and hit/miss counters.

Parameters:
DATA_W, 16, CPU and SRAM data width.
ADDR_W, 18, word address width (CPU and SRAM).
SETS, 64, number of sets; power of two, >=2.
WAYS, 2, associativity; 1, 2 or 4.
LINE_WORDS, 2, words per line; 1, 2 or 4.
SRAM_LAT, 4, cycles per SRAM word access; >=2.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
cpu_rd  in  1  read request, held stable while cpu_stall=1
cpu_wr  in  1  write request, held stable while cpu_stall=1
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, valid when cpu_rd=1 and cpu_stall=0
cpu_stall  out  1  combinational; 1 = hold pipeline
cache_flush  in  1  invalidate all lines
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data
sram_dq_oe  out  1  top-level tristate enable for sram_wdata
sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active-low
hit_cnt  out  16  saturating read-hit counter
miss_cnt  out  16  saturating read-miss counter

Behaviour:
- Reset (rst=0, async): state IDLE; all valid and PLRU bits 0; counters 0; all SRAM strobes 1; sram_dq_oe 0; sram_addr/sram_wdata 0; cpu_rdata 0. Reset mid-fill/mid-write aborts; the partial line is never validated.
- Address split: offset = low log2(LINE_WORDS) bits, index = next log2(SETS) bits, tag = remainder.
- States: IDLE, FILL, WR, WR_ACK.
- IDLE priority: cache_flush > cpu_wr > cpu_rd. cpu_rd and cpu_wr both 1 is treated as a write.
- Flush in IDLE: clears all valid and PLRU bits in one cycle; cpu_stall=1 that cycle; stays IDLE. Flush outside IDLE is ignored.
- Read hit in IDLE: cpu_rdata = hit way's word combinationally; cpu_stall=0; PLRU updated to protect the hit way; hit_cnt increments unless the previous state was FILL.
- Read miss in IDLE: cpu_stall=1; miss_cnt increments; victim selected; go to FILL.
  - Victim: first invalid way (lowest index), otherwise the PLRU way.
- FILL: reads LINE_WORDS words, offsets 0..LINE_WORDS-1, SRAM_LAT cycles each.
  - sram_ce_n=0, sram_oe_n=0, ub/lb=0; sram_addr is stable for the whole word.
  - sram_rdata is sampled on the last cycle of each word.
  - After the final word: write tag, set valid, return to IDLE, where the held request hits.
  - Read-miss stall = 1 + LINE_WORDS*SRAM_LAT cycles.
- WR: SRAM_LAT cycles. sram_ce_n=0, sram_dq_oe=1, ub/lb=0; sram_we_n=0 on all but the last cycle (address/data hold).
  - On write hit, the cached word is updated on WR entry; PLRU is not updated.
  - On write miss, there is no allocation.
- WR_ACK: exactly one cycle with cpu_stall=0, so the pipeline consumes the write; then IDLE.
  - Write stall = 1 + SRAM_LAT cycles.
- cpu_stall=1 in FILL and WR, and in IDLE on miss, write or flush.
- Counters: saturate at 16'hFFFF; no wrap.
- WAYS=1: no PLRU state; victim is way 0.
- Storage: valid and PLRU bits are flops; tag/data arrays are inferred RAM read combinationally by index.

Decomposition:
- Package cache_sa_pkg holds the state enum, the derived widths (OFF_W, IDX_W, TAG_W via $clog2) and the PLRU update/victim functions.
- One sub-module, plru_tree: per-set PLRU bits with a touch port and a victim port.

Test Plan:
- Defaults; read 0x00010 cold -> miss_cnt=1; cpu_stall high 9 cycles; SRAM reads 0x00010, 0x00011; cpu_rdata=SRAM[0x10]. Then read 0x00011 -> 0-cycle hit, hit_cnt=1.
- Write 0x00010=0xBEEF after the fill -> stall 5 cycles; sram_we_n low 3 cycles; WR_ACK; re-read 0x00010 -> hit, 0xBEEF.
- Write-miss 0x02000=0x1234 -> SRAM written, no fill, miss_cnt unchanged; next read 0x02000 -> miss.
- Three tags to set 0, accessed A, B, A, then C -> C replaces B; read A -> hit, read B -> miss.
- cache_flush in IDLE -> one stall cycle; previously cached 0x00010 -> miss.
- Assert rst=0 at cycle 3 of FILL -> strobes high immediately; after release, read the same address -> miss, full fill, counters restart from 0.
